// File: rtl/ibex_secure_result_decrypt_pkg.sv
// Shared types for the secure result decrypt path: FSM states and the tagged result record.
package ibex_secure_result_decrypt_pkg;

  localparam int SecTagW = 5;
  localparam int SecResW = 32 + SecTagW;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DRAIN} secure_dec_state_e;

  typedef struct packed {
    logic [31:0]        data;
    logic [SecTagW-1:0] tag;
  } sec_res_t;

endpackage

// File: rtl/aes128_cipher.sv
// Latency-accurate behavioural model of the AES-128 core: keyed invertible transform on the low word,
// delivered Latency cycles after valid_i is sampled.
module aes128_cipher #(
  parameter int Latency = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic         decrypt_i,
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic         valid_o,
  output logic [127:0] data_o
);

  function automatic logic [31:0] lane(input logic dec, input logic [63:0] k, input logic [31:0] d);
    logic [31:0] t;
    if (dec) begin
      t = d - k[63:32];
      return {t[4:0], t[31:5]} ^ k[31:0];
    end
    t = d ^ k[31:0];
    return {t[26:0], t[31:27]} + k[63:32];
  endfunction

  logic [Latency-1:0] vld;
  logic [127:0]       dat [Latency];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld <= '0;
      for (int i = 0; i < Latency; i++) dat[i] <= '0;
    end else begin
      vld[0] <= valid_i;
      dat[0] <= {data_i[127:32] ^ key_i[127:32], lane(decrypt_i, key_i[63:0], data_i[31:0])};
      for (int i = 1; i < Latency; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign valid_o = vld[Latency-1];
  assign data_o  = dat[Latency-1];

endmodule

// File: rtl/ibex_secure_dec_fifo.sv
// Tagged-result input buffer with synchronous flush; push+pop on a full buffer keeps the count.
module ibex_secure_dec_fifo
  import ibex_secure_result_decrypt_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [SecResW-1:0] data_i,
  input  logic               pop_i,
  output logic [SecResW-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int PtrW = $clog2(Depth);

  logic [SecResW-1:0] mem [Depth];
  logic [PtrW-1:0]    wptr, rptr;
  logic [PtrW:0]      count;
  logic               do_push, do_pop;

  assign full_o  = (count == (PtrW+1)'(Depth));
  assign empty_o = (count == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ibex_secure_result_decrypt.sv
// Decrypts tagged secure-ALU results in order and hands plaintext to writeback.
// Optional watchdog on the AES wait: define IBEX_SECURE_DEC_TIMEOUT_EN.
module ibex_secure_result_decrypt
  import ibex_secure_result_decrypt_pkg::*;
#(
  parameter bit EnableCrypto  = 1'b1,
  parameter int FifoDepth     = 2,
  parameter int TimeoutCycles = 32,
  parameter int AesLatency    = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [127:0]       aes_key_i,
  input  logic               aes_key_valid_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_data_i,
  input  logic [SecTagW-1:0] in_tag_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        out_data_o,
  output logic [SecTagW-1:0] out_tag_o,
  output logic               out_err_o,
  output logic               busy_o
);

  secure_dec_state_e  state;
  sec_res_t           work, fifo_head;
  logic [SecResW-1:0] fifo_head_raw;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               err, out_valid, aes_start, aes_done, key_lost, drain_pend;
  logic [127:0]       aes_out;
  logic [31:0]        aes_plain;
  logic [95:0]        unused_aes;

  assign fifo_push = in_valid_i && !fifo_full && !flush_i;
  assign fifo_pop  = (state == IDLE) && !fifo_empty && !flush_i;
  assign fifo_head = sec_res_t'(fifo_head_raw);

  ibex_secure_dec_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .data_i  ({in_data_i, in_tag_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  generate
    if (EnableCrypto) begin : g_aes
      aes128_cipher #(.Latency(AesLatency)) u_aes (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (aes_start),
        .decrypt_i (1'b1),
        .key_i     (aes_key_i),
        .data_i    ({96'd0, work.data}),
        .valid_o   (aes_done),
        .data_o    (aes_out)
      );
    end else begin : g_bypass
      assign aes_done = 1'b0;
      assign aes_out  = '0;
    end
  endgenerate

  assign aes_plain  = aes_out[31:0];
  assign unused_aes = aes_out[127:32];

`ifdef IBEX_SECURE_DEC_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_cnt;
`else
  assign drain_pend = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      work      <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      aes_start <= 1'b0;
      key_lost  <= 1'b0;
`ifdef IBEX_SECURE_DEC_TIMEOUT_EN
      tmo_cnt    <= '0;
      drain_pend <= 1'b0;
`endif
    end else begin
      aes_start <= 1'b0;
`ifdef IBEX_SECURE_DEC_TIMEOUT_EN
      if (aes_done) drain_pend <= 1'b0;
`endif
      case (state)
        IDLE: if (fifo_pop) begin
          work     <= fifo_head;
          err      <= 1'b0;
          key_lost <= 1'b0;
          if (!EnableCrypto) begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (aes_key_valid_i) begin
            aes_start <= 1'b1;
            state     <= WAIT;
`ifdef IBEX_SECURE_DEC_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end else begin
            work.data <= '0;
            err       <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        WAIT: begin
          if (flush_i) begin
            state <= aes_done ? IDLE : DRAIN;
          end else if (aes_done) begin
            // A key drop anywhere in the wait, including this cycle, poisons the entry.
            work.data <= (key_lost || !aes_key_valid_i) ? 32'd0 : aes_plain;
            err       <= key_lost || !aes_key_valid_i;
            out_valid <= 1'b1;
            state     <= HOLD;
`ifdef IBEX_SECURE_DEC_TIMEOUT_EN
          end else if (tmo_cnt == TmoW'(TimeoutCycles - 1)) begin
            work.data  <= '0;
            err        <= 1'b1;
            out_valid  <= 1'b1;
            drain_pend <= 1'b1;
            state      <= HOLD;
          end else begin
            tmo_cnt  <= tmo_cnt + 1'b1;
            key_lost <= key_lost || !aes_key_valid_i;
          end
`else
          end else begin
            key_lost <= key_lost || !aes_key_valid_i;
          end
`endif
        end
        HOLD: if (flush_i || out_ready_i) begin
          out_valid <= 1'b0;
          state     <= (drain_pend && !aes_done) ? DRAIN : IDLE;
        end
        DRAIN: if (aes_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = !fifo_full;
  assign out_valid_o = out_valid;
  assign out_data_o  = work.data;
  assign out_tag_o   = work.tag;
  assign out_err_o   = err;
  assign busy_o      = (state != IDLE) || !fifo_empty;

endmodule
